// File: rtl/riscv_mdu_pkg.sv
// riscv_mdu_pkg: shared opcode encodings and FSM states for the RV32M multiply/divide unit
package riscv_mdu_pkg;
   localparam int MDU_OP_WIDTH = 3;
   localparam logic [MDU_OP_WIDTH-1:0] OP_MUL    = 3'd0;
   localparam logic [MDU_OP_WIDTH-1:0] OP_MULH   = 3'd1;
   localparam logic [MDU_OP_WIDTH-1:0] OP_MULHSU = 3'd2;
   localparam logic [MDU_OP_WIDTH-1:0] OP_MULHU  = 3'd3;
   localparam logic [MDU_OP_WIDTH-1:0] OP_DIV    = 3'd4;
   localparam logic [MDU_OP_WIDTH-1:0] OP_DIVU   = 3'd5;
   localparam logic [MDU_OP_WIDTH-1:0] OP_REM    = 3'd6;
   localparam logic [MDU_OP_WIDTH-1:0] OP_REMU   = 3'd7;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_e;
endpackage

// File: rtl/riscv_mdu.sv
// riscv_mdu: radix-2 iterative RV32M multiply/divide unit sharing one adder and one shift register
module riscv_mdu
   import riscv_mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    flush_i,
   input  logic [MDU_OP_WIDTH-1:0] opcode_i,
   input  logic [XLEN-1:0]         op_a_i,
   input  logic [XLEN-1:0]         op_b_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   output logic [XLEN-1:0]         res_o,
   output logic                    resp_valid_o,
   input  logic                    resp_ready_i
);
   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_e              state_q, state_d;
   logic [CW-1:0]           cnt_q;
   logic [2*XLEN-1:0]       sr_q, step;
   logic [XLEN-1:0]         b_q, res_q, am, bm, v, inc, fin, special;
   logic [MDU_OP_WIDTH-1:0] op_q;
   logic                    neg_q, sa, sb, neg, dz, ovf, accept, is_div, hi_mul;
   logic [XLEN:0]           add_x, add_y;
   logic [XLEN+1:0]         sum;

   assign accept  = state_q == IDLE && req_valid_i && !flush_i;
   assign sa      = op_a_i[XLEN-1] && (opcode_i inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
   assign sb      = op_b_i[XLEN-1] && (opcode_i inside {OP_MULH, OP_DIV, OP_REM});
   assign am      = sa ? -op_a_i : op_a_i;
   assign bm      = sb ? -op_b_i : op_b_i;
   assign neg     = opcode_i == OP_REM ? sa : sa ^ sb;
   assign dz      = opcode_i[2] && op_b_i == '0;
   assign ovf     = (opcode_i == OP_DIV || opcode_i == OP_REM) && op_a_i == MIN && op_b_i == '1;
   assign special = dz ? (opcode_i[1] ? op_a_i : '1) : (opcode_i[1] ? '0 : op_a_i);

   // multiply keeps {partial, multiplier} shifting right; divide keeps {remainder, quotient} shifting left
   assign is_div = op_q[2];
   assign hi_mul = !is_div && op_q != OP_MUL;
   assign add_x  = is_div ? sr_q[2*XLEN-1:XLEN-1] : {1'b0, sr_q[2*XLEN-1:XLEN]};
   assign add_y  = is_div ? ~{1'b0, b_q} : (sr_q[0] ? {1'b0, b_q} : '0);
   assign sum    = {1'b0, add_x} + {1'b0, add_y} + {{(XLEN+1){1'b0}}, is_div};
   assign step   = !is_div ? {sum[XLEN:0], sr_q[XLEN-1:1]}
                 : sum[XLEN+1] ? {sum[XLEN-1:0], sr_q[XLEN-2:0], 1'b1} : {sr_q[2*XLEN-2:0], 1'b0};
   // high half of a negated product borrows from the low half only when the low half is zero
   assign v      = (is_div ? op_q[1] : hi_mul) ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
   assign inc    = {{(XLEN-1){1'b0}}, !hi_mul || step[XLEN-1:0] == '0};
   assign fin    = neg_q ? ~v + inc : v;

   assign req_ready_o  = state_q == IDLE;
   assign resp_valid_o = state_q == DONE;
   assign res_o        = res_q;

   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // next state: special cases skip BUSY, flush always returns to IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = accept ? (dz || ovf ? DONE : BUSY) : IDLE;
         BUSY:    state_d = cnt_q == LAST ? DONE : BUSY;
         DONE:    state_d = resp_ready_i ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
      if (flush_i) state_d = IDLE;
   end

   // datapath: latch magnitudes on accept, iterate while busy, capture corrected result on the last step
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         op_q  <= '0;
         sr_q  <= '0;
         b_q   <= '0;
         neg_q <= 1'b0;
         cnt_q <= '0;
         res_q <= '0;
      end else if (accept) begin
         op_q  <= opcode_i;
         sr_q  <= {{XLEN{1'b0}}, am};
         b_q   <= bm;
         neg_q <= neg;
         cnt_q <= '0;
         if (dz || ovf) res_q <= special;
      end else if (state_q == BUSY && !flush_i) begin
         sr_q  <= step;
         cnt_q <= cnt_q + 1'b1;
         if (cnt_q == LAST) res_q <= fin;
      end
   end
endmodule

// File: doc/riscv_mdu.md
RISCV_MDU -- requirements
Module: riscv_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width (even, >= 8).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port flush_i, input, 1, abort of any in-flight operation.
REQ-005 SHALL have port opcode_i, input, MDU_OP_WIDTH, the operation, encoded as RV32M funct3.
REQ-006 SHALL have ports op_a_i and op_b_i, input, XLEN each, the rs1 and rs2 operands.
REQ-007 SHALL have port req_valid_i, input, 1, request valid.
REQ-008 SHALL have port req_ready_o, output, 1, ready to accept a request.
REQ-009 SHALL have port res_o, output, XLEN, the result.
REQ-010 SHALL have port resp_valid_o, output, 1, result valid.
REQ-011 SHALL have port resp_ready_i, input, 1, consumer accepts the result.

Function
REQ-012 SHALL implement: MUL=0 (low half), MULH=1 (signed x signed, high), MULHSU=2 (signed x unsigned, high), MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
REQ-013 SHALL use an FSM with states IDLE, BUSY and DONE; req_ready_o=1 only in IDLE, resp_valid_o=1 only in DONE.
REQ-014 SHALL accept a request on a clk_i edge where req_valid_i&&req_ready_o&&!flush_i, latching opcode and operand magnitudes plus sign flags.
REQ-015 SHALL run the normal path as radix-2 iterative (shift-add multiply, restoring divide on magnitudes), one step per BUSY cycle, XLEN steps, counted by a $clog2(XLEN)-bit counter.
REQ-016 SHALL give normal-path latency as follows: request accepted at edge T makes resp_valid_o=1 from cycle T+XLEN+1; sign correction (two's-complement negate) is applied on the BUSY->DONE transition.
REQ-017 SHALL handle divide by zero (op_b_i==0, opcodes 4..7) as IDLE->DONE directly (latency 1): DIV/DIVU give all-ones, REM/REMU give op_a_i.
REQ-018 SHALL handle signed overflow (DIV/REM, op_a_i=-2^(XLEN-1), op_b_i=-1) with latency 1: DIV gives op_a_i, REM gives 0.
REQ-019 SHALL use the sign rules: quotient negative iff operand signs differ and divisor nonzero; remainder takes the dividend sign; MULHSU treats only op_a_i as signed.
REQ-020 SHALL, in DONE, hold res_o and resp_valid_o stable until resp_ready_i=1, then go to IDLE on that edge; no request is accepted in the same cycle.
REQ-021 SHALL, on flush_i=1 in any state, go to IDLE on the next edge with resp_valid_o=0 and the result discarded; flush_i with req_valid_i in IDLE drops the request.
REQ-022 SHALL keep res_o undefined-free: it holds its last value outside DONE (0 after reset).

Reset
REQ-023 SHALL, on rst_i=1 at a clk_i edge, set state=IDLE, counter=0, all datapath registers=0, res_o=0, resp_valid_o=0, req_ready_o=1 from the next cycle.
REQ-024 SHALL give rst_i priority over flush_i and the handshakes; reset mid-BUSY or mid-DONE abandons the operation with no response.

Structure
REQ-025 SHALL place MDU_OP_WIDTH=3, the eight opcode localparams and the FSM state enum in a shared package riscv_mdu_pkg, imported as for riscv_alu_pkg.
REQ-026 SHALL be a single module with no sub-module; the multiply and divide share one XLEN+1-bit adder/subtractor and one 2*XLEN-bit shift register.

Verification (XLEN=32, T = accept edge)
REQ-027 SHALL cover: MUL 7 x 0xFFFFFFFD -> res_o=0xFFFFFFEB, resp_valid_o first high at T+33.
REQ-028 SHALL cover the high-half multiplies: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-029 SHALL cover signed divide: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-030 SHALL cover the special cases at T+1: DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-031 SHALL cover backpressure: resp_ready_i=0 for 5 cycles in DONE -> res_o and resp_valid_o stable and req_ready_o=0; resp_ready_i=1 -> IDLE next cycle.
REQ-032 SHALL cover abort: flush_i pulse at T+10 of a DIV -> IDLE at T+11 with no resp_valid_o; rst_i at T+5 of a MUL -> res_o=0 and req_ready_o=1 next cycle.
